// File: rtl/advanced_counter_pkg.sv
// advanced_counter_pkg: shared width and direction constants for the cascadable counter
package advanced_counter_pkg;
  localparam int CNT_WIDTH = 4;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/advanced_counter_inc_edge_sync.sv
// inc_edge_sync: two-flop synchroniser plus edge flop giving one clk pulse per async rise
module inc_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);
  logic [2:0] r_sync;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_sync <= '0;
    else r_sync <= {r_sync[1:0], async_in};
  assign rise_pulse = r_sync[1] & ~r_sync[2];
endmodule

// File: rtl/advanced_counter.sv
// advanced_counter: cascadable up/down counter stepped by a synchronised inc strobe with optional wrap value
module advanced_counter
  import advanced_counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             up_down_sel,
  input  logic             carry_en,
  input  logic             carry_in,
  input  logic             max_en,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] cnt_out,
  output logic             carry_out
);
  logic             w_inc_rise, w_gate, w_step, w_up;
  logic [WIDTH-1:0] w_top, w_next, r_cnt;
  inc_edge_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .async_in  (inc),
    .rise_pulse(w_inc_rise)
  );
  assign w_top  = max_en ? max_val : '1;
  assign w_gate = carry_en ? carry_in : 1'b1;
  assign w_step = w_inc_rise & w_gate;
  assign w_up   = up_down_sel == DIR_UP;
  // A count above a lowered top wraps to 0 going up and clamps to top going down
  always_comb
    w_next = w_up ? ((r_cnt >= w_top) ? '0 : r_cnt + 1'b1)
                  : ((r_cnt == '0 || r_cnt > w_top) ? w_top : r_cnt - 1'b1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (w_step) r_cnt <= w_next;
  assign cnt_out   = r_cnt;
  assign carry_out = w_gate & (w_up ? (r_cnt >= w_top) : (r_cnt == '0));
endmodule

// File: tb/tb_advanced_counter.sv
// tb_advanced_counter: random and directed stimulus against an edge-counting reference model
module tb_advanced_counter;
  logic       clk = 1'b0, reset = 1'b0, inc = 1'b0;
  logic       up_down_sel = 1'b0, carry_en = 1'b0, carry_in = 1'b0, max_en = 1'b0;
  logic [3:0] max_val = 4'd0;
  logic [3:0] cnt_out, lo_cnt, hi_cnt;
  logic       carry_out, lo_co, hi_co;
  int         n_chk = 0, n_pass = 0;
  int         m_cnt = 0, c_cnt = 0;
  bit         last_inc = 1'b0;
  bit         rq[$] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  advanced_counter dut (
    .clk(clk), .reset(reset), .inc(inc), .up_down_sel(up_down_sel),
    .carry_en(carry_en), .carry_in(carry_in), .max_en(max_en), .max_val(max_val),
    .cnt_out(cnt_out), .carry_out(carry_out)
  );
  advanced_counter lo (
    .clk(clk), .reset(reset), .inc(inc), .up_down_sel(1'b0),
    .carry_en(1'b0), .carry_in(1'b0), .max_en(1'b0), .max_val(4'd0),
    .cnt_out(lo_cnt), .carry_out(lo_co)
  );
  advanced_counter hi (
    .clk(clk), .reset(reset), .inc(inc), .up_down_sel(1'b0),
    .carry_en(1'b1), .carry_in(lo_co), .max_en(1'b0), .max_val(4'd0),
    .cnt_out(hi_cnt), .carry_out(hi_co)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
  endtask

  function automatic int m_top();
    return max_en ? int'(max_val) : 15;
  endfunction

  function automatic bit m_gate();
    return carry_en ? carry_in : 1'b1;
  endfunction

  // Every inc rise seen at a clk edge is applied two edges later
  always @(posedge clk or negedge reset) begin : model
    bit raw, apply;
    int top;
    if (!reset) begin
      m_cnt = 0; c_cnt = 0; last_inc = 1'b0; rq = '{1'b0, 1'b0};
    end else begin
      raw = inc & ~last_inc;
      last_inc = inc;
      rq.push_back(raw);
      apply = rq.pop_front();
      top = m_top();
      if (apply) begin
        c_cnt = (c_cnt + 1) % 256;
        if (m_gate())
          m_cnt = (up_down_sel == 1'b0) ? ((m_cnt >= top) ? 0 : m_cnt + 1)
                                        : ((m_cnt == 0 || m_cnt > top) ? top : m_cnt - 1);
      end
    end
  end

  always @(negedge clk) begin
    chk("cnt", 32'(cnt_out), m_cnt);
    chk("carry", 32'(carry_out),
        32'(m_gate() & ((up_down_sel == 1'b0) ? (m_cnt >= m_top()) : (m_cnt == 0))));
    chk("chain", 32'({hi_cnt, lo_cnt}), c_cnt);
  end

  task automatic pulse(input int lo_cyc, input int hi_cyc);
    inc = 1'b0;
    repeat (lo_cyc) begin @(posedge clk); #2; end
    inc = 1'b1;
    repeat (hi_cyc) begin @(posedge clk); #2; end
  endtask

  task automatic set(input bit ud, input bit ce, input bit ci, input bit me, input logic [3:0] mv);
    up_down_sel = ud; carry_en = ce; carry_in = ci; max_en = me; max_val = mv;
  endtask

  task automatic reach(input int v);
    for (int i = 0; i < 20 && m_cnt != v; i++) pulse(2, 3);
    chk("reach", 32'(cnt_out), v);
  endtask

  initial begin
    #3;
    chk("rst_cnt", 32'(cnt_out), 0);
    chk("rst_carry", 32'(carry_out), 0);
    @(posedge clk); #2;
    reset = 1'b1;
    set(0, 0, 0, 0, 4'd0);
    repeat (16) pulse(2, 1);
    pulse(2, 3);
    set(0, 1, 0, 0, 4'd0);
    repeat (13) pulse(2, 1);
    carry_in = 1'b1;
    repeat (5) pulse(2, 1);
    set(0, 0, 0, 1, 4'd1);
    repeat (4) pulse(2, 1);
    max_val = 4'd8;
    repeat (10) pulse(2, 1);
    reach(3);
    set(1, 0, 0, 1, 4'd8);
    repeat (5) pulse(2, 3);
    set(0, 0, 0, 1, 4'd8);
    reach(6);
    max_val = 4'd2;
    pulse(2, 3);
    chk("lower_up", 32'(cnt_out), 0);
    max_val = 4'd8;
    reach(6);
    set(1, 0, 0, 1, 4'd2);
    pulse(2, 3);
    chk("lower_down", 32'(cnt_out), 2);
    set(0, 0, 0, 0, 4'd0);
    reach(5);
    inc = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    inc = 1'b1;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("rst_async", 32'(cnt_out), 0);
    inc = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (5) begin @(posedge clk); #2; end
    chk("no_spur", 32'(cnt_out), 0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0)
        set(1'($urandom_range(1)), 1'($urandom_range(3) == 0), 1'($urandom_range(1)),
            1'($urandom_range(1)), 4'($urandom_range(15)));
      pulse(int'($urandom_range(3, 1)), int'($urandom_range(3, 1)));
    end
    repeat (4) begin @(posedge clk); #2; end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
